// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing generator: pixel-rate divider, h/v counters,
//            sync pulses, data-enable, coordinates and line/frame pulses.
//            Build option: define VGA_TIMING_REG_OUT_EN to register every
//            output (one clock of latency, outputs stay mutually aligned).
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   H_RES    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_RES    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       DE,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       line_start,
    output logic       frame_start
);

    localparam int c_h_total = H_RES + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_RES + V_FP + V_SYNC + V_BP;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0]         c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0]         c_v_last   = 10'(c_v_total - 1);

    // Decode bounds are 11 bits wide so a total of exactly 1024 still compares correctly
    localparam logic [10:0] c_h_act  = 11'(H_RES);
    localparam logic [10:0] c_hs_beg = 11'(H_RES + H_FP);
    localparam logic [10:0] c_hs_end = 11'(H_RES + H_FP + H_SYNC);
    localparam logic [10:0] c_v_act  = 11'(V_RES);
    localparam logic [10:0] c_vs_beg = 11'(V_RES + V_FP);
    localparam logic [10:0] c_vs_end = 11'(V_RES + V_FP + V_SYNC);

    logic [c_div_w-1:0] r_div_cnt;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;

    logic               w_tick_raw;
    logic               w_h_wrap;
    logic [10:0]        w_h_ext;
    logic [10:0]        w_v_ext;
    logic               w_hs_act;
    logic               w_vs_act;

    logic               w_pix_tick;
    logic               w_h_sync;
    logic               w_v_sync;
    logic               w_de;
    logic [9:0]         w_x_pixel;
    logic [9:0]         w_y_pixel;
    logic               w_line_start;
    logic               w_frame_start;

    // With CLK_DIV=1 the divider is a single bit pinned at 0, so the tick is permanent
    assign w_tick_raw = (r_div_cnt == c_div_last);
    assign w_h_wrap   = w_tick_raw && (r_h_cnt == c_h_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick_raw) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
        end else if (w_tick_raw) begin
            if (r_h_cnt == c_h_last) begin
                r_h_cnt <= '0;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            if (r_v_cnt == c_v_last) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end
    end

    assign w_h_ext  = {1'b0, r_h_cnt};
    assign w_v_ext  = {1'b0, r_v_cnt};
    assign w_hs_act = (w_h_ext >= c_hs_beg) && (w_h_ext < c_hs_end);
    assign w_vs_act = (w_v_ext >= c_vs_beg) && (w_v_ext < c_vs_end);

    // Reset overrides every decode so downstream stages see a clean blank immediately
    assign w_pix_tick    = !reset && w_tick_raw;
    assign w_de          = !reset && (w_h_ext < c_h_act) && (w_v_ext < c_v_act);
    assign w_h_sync      = (!reset && w_hs_act) ? SYNC_POL : ~SYNC_POL;
    assign w_v_sync      = (!reset && w_vs_act) ? SYNC_POL : ~SYNC_POL;
    assign w_x_pixel     = reset ? 10'd0 : r_h_cnt;
    assign w_y_pixel     = reset ? 10'd0 : r_v_cnt;
    assign w_line_start  = w_pix_tick && (r_h_cnt == 10'd0);
    assign w_frame_start = w_line_start && (r_v_cnt == 10'd0);

`ifdef VGA_TIMING_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_tick    <= 1'b0;
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            DE          <= 1'b0;
            x_pixel     <= 10'd0;
            y_pixel     <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= w_pix_tick;
            h_sync      <= w_h_sync;
            v_sync      <= w_v_sync;
            DE          <= w_de;
            x_pixel     <= w_x_pixel;
            y_pixel     <= w_y_pixel;
            line_start  <= w_line_start;
            frame_start <= w_frame_start;
        end
    end
`else
    assign pix_tick    = w_pix_tick;
    assign h_sync      = w_h_sync;
    assign v_sync      = w_v_sync;
    assign DE          = w_de;
    assign x_pixel     = w_x_pixel;
    assign y_pixel     = w_y_pixel;
    assign line_start  = w_line_start;
    assign frame_start = w_frame_start;
`endif

endmodule
`default_nettype wire
